// File: rtl/dmem_wait.sv
// Data memory with req/done handshake, LATENCY wait cycles and byte/half/word
// access with optional sign extension; misaligned or reserved-size requests fault.
module dmem_wait #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        signed_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int unsigned CW = 4;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           sgn_q, sgn_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;

    logic [31:0]    mem_q [DEPTH];

    logic           fault_c;
    logic           access_c;
    logic [AW-1:0]  idx_c;
    logic [31:0]    rd_word_c;
    logic [31:0]    wr_word_c;
    logic [31:0]    ld_val_c;
    logic [7:0]     byte_c;
    logic [15:0]    half_c;
    logic           unused_addr_c;

    // Upper address bits are deliberately ignored: the word index wraps.
    assign unused_addr_c = ^addr[31:AW+2];

    assign idx_c     = addr_q[AW+1:2];
    assign rd_word_c = mem_q[idx_c];

    always_comb begin
        fault_c = 1'b0;
        case (size)
            SZ_BYTE: fault_c = 1'b0;
            SZ_HALF: fault_c = addr[0];
            SZ_WORD: fault_c = |addr[1:0];
            default: fault_c = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane merge for partial stores.
    always_comb begin
        byte_c    = rd_word_c[{addr_q[1:0], 3'b000} +: 8];
        half_c    = rd_word_c[{addr_q[1], 4'b0000} +: 16];
        ld_val_c  = rd_word_c;
        wr_word_c = rd_word_c;
        case (size_q)
            SZ_BYTE: begin
                ld_val_c = {{24{sgn_q & byte_c[7]}}, byte_c};
                wr_word_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                ld_val_c = {{16{sgn_q & half_c[15]}}, half_c};
                wr_word_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                ld_val_c  = rd_word_c;
                wr_word_c = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        access_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sgn_d   = signed_ld;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    if (fault_c) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d   = CW'(LATENCY);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    access_c = 1'b1;
                    state_d  = S_RESP;
                    done_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = ld_val_c;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Reset in the commit cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && access_c && we_q) begin
            mem_q[idx_c] <= wr_word_c;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: doc/dmem_wait.md
# dmem_wait

Parametrised data memory with a request/done handshake, configurable wait states, and byte/halfword/word access with optional sign extension. It succeeds the fixed single-cycle data memory in the MIPS top level. The processor holds its request until `done` and stalls on `busy`, which lets the core run against slow memory and execute `lb/lbu/lh/lhu/sb/sh` as well as `lw/sw`. Misaligned accesses are trapped, not silently truncated.

## Interface
- `DEPTH`, 64: memory depth in 32-bit words; power of two, 4..4096.
- `LATENCY`, 2: wait cycles before the memory access; 0..15.
- `AW`, `$clog2(DEPTH)`: word-index width (derived; do not override).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request valid; sampled only while the FSM is in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as a fault).
- `signed_ld` in 1: sign-extend byte/halfword loads; ignored for stores and words.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `busy` out 1: high in WAIT and RESP; a new request is not accepted.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = misaligned or reserved size, with no memory access.
- `rdata` out 32: load result, registered; holds its value until the next load completes.

## Operation
- States: IDLE, WAIT, RESP. Reset forces IDLE, `cnt`=0, `busy`=0, `done`=0, `err`=0, `rdata`=0. Memory contents are not reset.
- IDLE + `req`: latch `we`, `size`, `signed_ld`, `addr`, `wdata`.
  - On fault: go to RESP with `err`=1.
  - Otherwise: `cnt`<=LATENCY, go to WAIT.
- Fault conditions: `size`=11; half with `addr[0]`=1; word with `addr[1:0]`≠0.
- WAIT, `cnt`≠0: `cnt`<=`cnt`-1.
- WAIT, `cnt`=0: perform the access at this edge, then go to RESP with `err`=0.
- RESP: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- Word index is `addr[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Byte lanes are little-endian: byte lane k = bits [8k+7:8k], selected by `addr[1:0]`. Half lane = `addr[1]`.
- Store byte/half writes only the addressed lane(s), using the low bits of the latched `wdata`. All other bits of the word are unchanged.
- Load: the selected lane is right-aligned in `rdata`. Upper bits are zero-filled, or copies of the lane MSB if `signed_ld`=1.
- Stores and faults leave `rdata` unchanged.
- `req` in WAIT/RESP is ignored; the requester must hold or re-present it.
- Input changes after acceptance have no effect, because all fields are latched.

## Timing
- Request accepted at edge E0 (cycle 0 = IDLE with `req`=1).
- Normal access:
  - WAIT occupies cycles 1..LATENCY+1.
  - The write commits, or `rdata` updates, at the edge ending cycle LATENCY+1.
  - `done` is high in cycle LATENCY+2, with `rdata` valid in the same cycle.
- Fault: `done`=`err`=1 in cycle 1.
- Throughput: the next accept is possible in cycle LATENCY+3; that is, one accept per LATENCY+3 cycles.
- `busy` is registered: high from cycle 1 through the `done` cycle inclusive.
- Reset has priority in every state. Reset asserted in the cycle a write would commit suppresses that write. Outputs take their reset values in the cycle after the reset edge.

## Test plan
- Reset, then store word 0xDEADBEEF to 0x10, then load word from 0x10 (LATENCY=2): `done` in cycle 4 of each access; `rdata`=0xDEADBEEF; `busy`=1 for cycles 1-4.
- After 0xDEADBEEF at 0x10: `sb` 0x55 to 0x11, then `lw` 0x10 → 0xDEAD55EF. `lb` 0x13 → 0xFFFFFFDE. `lbu` 0x13 → 0x000000DE. `lh` 0x12 → 0xFFFFDEAD.
- `lw` 0x12, `lh` 0x11, and `size`=11: each gives `done`=`err`=1 in cycle 1; memory and `rdata` unchanged.
- DEPTH=64: store 0x12345678 to 0x100, then load 0x000 → 0x12345678 (wrap).
- LATENCY=0: load completes with `done` in cycle 2. Toggling `req` and `addr` during `busy` does not change the result or start a second access.
- Assert `reset` in cycle 3 of a LATENCY=2 store to 0x20 holding 0x0: the write is suppressed, the following `lw` 0x20 returns 0x0, and `done` never pulses for the aborted request.
